// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite master port.
// Contents: AXI response codes, default protection value, the write and read
// engine state encodings, and a response classification helper.
package axil_pkg;

  localparam int unsigned AXIL_RESP_WIDTH = 2;
  localparam int unsigned AXIL_PROT_WIDTH = 3;

  localparam logic [AXIL_RESP_WIDTH-1:0] AXIL_OKAY   = 2'd0;
  localparam logic [AXIL_RESP_WIDTH-1:0] AXIL_EXOKAY = 2'd1;
  localparam logic [AXIL_RESP_WIDTH-1:0] AXIL_SLVERR = 2'd2;
  localparam logic [AXIL_RESP_WIDTH-1:0] AXIL_DECERR = 2'd3;

  // Unprivileged, secure, data access.
  localparam logic [AXIL_PROT_WIDTH-1:0] AXIL_PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_DATA = 2'd1,
    W_RESP      = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // Any response other than OKAY is counted as an error, EXOKAY included.
  function automatic logic resp_is_err(input logic [AXIL_RESP_WIDTH-1:0] resp);
    return resp inside {AXIL_EXOKAY, AXIL_SLVERR, AXIL_DECERR};
  endfunction

endpackage

// File: rtl/axil_wr_engine.sv
// Write engine of the AXI4-Lite master port.
// Accepts a single-cycle write request, issues AW and W with independent
// handshake tracking, waits for B, reports BRESP and counts error responses.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   wr_start/addr/data/strb             user request (taken only when wr_ready)
//   wr_ready, wr_done, wr_resp          engine idle, completion pulse, last BRESP
//   wr_err_count                        saturating count of non-OKAY BRESPs
//   m_axil_aw*/w*/b*                    AXI4-Lite write channels
module axil_wr_engine
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_start,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [STRB_WIDTH-1:0]      wr_strb,
  output logic                       wr_ready,
  output logic                       wr_done,
  output logic [AXIL_RESP_WIDTH-1:0] wr_resp,
  output logic [ERR_CNT_WIDTH-1:0]   wr_err_count,
  output logic [ADDR_WIDTH-1:0]      m_axil_awaddr,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [DATA_WIDTH-1:0]      m_axil_wdata,
  output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [AXIL_RESP_WIDTH-1:0] m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready
);

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  wr_state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        data_q, data_d;
  logic [STRB_WIDTH-1:0]        strb_q, strb_d;
  logic                         awvalid_q, awvalid_d;
  logic                         wvalid_q, wvalid_d;
  logic                         bready_q, bready_d;
  logic                         ready_q, ready_d;
  logic                         done_q, done_d;
  logic [AXIL_RESP_WIDTH-1:0]   resp_q, resp_d;
  logic [ERR_CNT_WIDTH-1:0]     err_q, err_d;

  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign aw_hs = awvalid_q & m_axil_awready;
  assign w_hs  = wvalid_q & m_axil_wready;
  assign b_hs  = bready_q & m_axil_bvalid;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    resp_d    = resp_q;
    err_d     = err_q;

    case (state_q)
      W_IDLE: begin
        if (wr_start) begin
          addr_d    = wr_addr;
          data_d    = wr_data;
          strb_d    = wr_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          ready_d   = 1'b0;
          state_d   = W_ADDR_DATA;
        end
      end

      W_ADDR_DATA: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // A channel is finished once its valid has dropped or handshakes now.
        if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
          bready_d = 1'b1;
          state_d  = W_RESP;
        end
      end

      W_RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          resp_d   = m_axil_bresp;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          state_d  = W_IDLE;
          if (resp_is_err(m_axil_bresp) && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_CNT_WIDTH'(1);
          end
        end
      end

      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        ready_d   = 1'b1;
        state_d   = W_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      resp_q    <= AXIL_OKAY;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
    end
  end

  assign wr_ready       = ready_q;
  assign wr_done        = done_q;
  assign wr_resp        = resp_q;
  assign wr_err_count   = err_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = strb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;

endmodule

// File: rtl/axil_master_port.sv
// AXI4-Lite master port: turns single-cycle user write/read requests into
// AXI4-Lite transactions. Write and read engines run independently.
// Ports:
//   clk, rst_n                                clock, synchronous active-low reset
//   wr_start/addr/data/strb -> wr_ready/done/resp/err_count   write request side
//   rd_start/addr -> rd_ready/done/data/resp/err_count        read request side
//   m_axil_*                                  AXI4-Lite master interface
module axil_master_port
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_start,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [STRB_WIDTH-1:0]      wr_strb,
  output logic                       wr_ready,
  output logic                       wr_done,
  output logic [AXIL_RESP_WIDTH-1:0] wr_resp,
  input  logic                       rd_start,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic                       rd_ready,
  output logic                       rd_done,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [AXIL_RESP_WIDTH-1:0] rd_resp,
  output logic [ERR_CNT_WIDTH-1:0]   wr_err_count,
  output logic [ERR_CNT_WIDTH-1:0]   rd_err_count,
  output logic [ADDR_WIDTH-1:0]      m_axil_awaddr,
  output logic [AXIL_PROT_WIDTH-1:0] m_axil_awprot,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [DATA_WIDTH-1:0]      m_axil_wdata,
  output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [AXIL_RESP_WIDTH-1:0] m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  output logic [ADDR_WIDTH-1:0]      m_axil_araddr,
  output logic [AXIL_PROT_WIDTH-1:0] m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [DATA_WIDTH-1:0]      m_axil_rdata,
  input  logic [AXIL_RESP_WIDTH-1:0] m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
);

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  assign m_axil_awprot = AXIL_PROT_DEFAULT;
  assign m_axil_arprot = AXIL_PROT_DEFAULT;

  // Write path.
  axil_wr_engine #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .STRB_WIDTH    (STRB_WIDTH),
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_wr_engine (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_start       (wr_start),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_strb        (wr_strb),
    .wr_ready       (wr_ready),
    .wr_done        (wr_done),
    .wr_resp        (wr_resp),
    .wr_err_count   (wr_err_count),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready)
  );

  // Read path.
  rd_state_t                  rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0]      araddr_q, araddr_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  logic                       rd_ready_q, rd_ready_d;
  logic                       rd_done_q, rd_done_d;
  logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [AXIL_RESP_WIDTH-1:0] rd_resp_q, rd_resp_d;
  logic [ERR_CNT_WIDTH-1:0]   rd_err_q, rd_err_d;

  // Read next-state and next-output logic.
  always_comb begin
    rstate_d   = rstate_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rd_ready_d = rd_ready_q;
    rd_done_d  = 1'b0;
    rd_data_d  = rd_data_q;
    rd_resp_d  = rd_resp_q;
    rd_err_d   = rd_err_q;

    case (rstate_q)
      R_IDLE: begin
        if (rd_start) begin
          araddr_d   = rd_addr;
          arvalid_d  = 1'b1;
          rd_ready_d = 1'b0;
          rstate_d   = R_ADDR;
        end
      end

      R_ADDR: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          rstate_d  = R_DATA;
        end
      end

      R_DATA: begin
        if (rready_q && m_axil_rvalid) begin
          rready_d   = 1'b0;
          rd_data_d  = m_axil_rdata;
          rd_resp_d  = m_axil_rresp;
          rd_done_d  = 1'b1;
          rd_ready_d = 1'b1;
          rstate_d   = R_IDLE;
          if (resp_is_err(m_axil_rresp) && (rd_err_q != ERR_MAX)) begin
            rd_err_d = rd_err_q + ERR_CNT_WIDTH'(1);
          end
        end
      end

      default: begin
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
        rd_ready_d = 1'b1;
        rstate_d   = R_IDLE;
      end
    endcase
  end

  // Read state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate_q   <= R_IDLE;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rd_ready_q <= 1'b1;
      rd_done_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_resp_q  <= AXIL_OKAY;
      rd_err_q   <= '0;
    end else begin
      rstate_q   <= rstate_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rd_ready_q <= rd_ready_d;
      rd_done_q  <= rd_done_d;
      rd_data_q  <= rd_data_d;
      rd_resp_q  <= rd_resp_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign m_axil_araddr  = araddr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign rd_ready       = rd_ready_q;
  assign rd_done        = rd_done_q;
  assign rd_data        = rd_data_q;
  assign rd_resp        = rd_resp_q;
  assign rd_err_count   = rd_err_q;

endmodule

// File: tb/tb_axil_master_port.sv
// Self-checking bench for axil_master_port with a small AXI4-Lite RAM slave.
module tb_axil_master_port;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned SW = 4;
  localparam int unsigned EW = 8;

  logic clk;
  logic rst_n;
  logic wr_start, rd_start;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic wr_ready, wr_done, rd_ready, rd_done;
  logic [1:0] wr_resp, rd_resp;
  logic [DW-1:0] rd_data;
  logic [EW-1:0] wr_err_count, rd_err_count;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0] m_axil_awprot, m_axil_arprot;
  logic m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DW-1:0] m_axil_wdata, m_axil_rdata;
  logic [SW-1:0] m_axil_wstrb;
  logic [1:0] m_axil_bresp, m_axil_rresp;
  logic m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic m_axil_rvalid, m_axil_rready;

  int unsigned n_tests, n_fail;

  axil_master_port #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_ready(wr_ready), .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_done(rd_done),
    .rd_data(rd_data), .rd_resp(rd_resp),
    .wr_err_count(wr_err_count), .rd_err_count(rd_err_count),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- slave model (RAM, configurable delays/responses) -------
  int unsigned cfg_aw_delay;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic        cfg_b_hold;
  int unsigned aw_wait;
  logic        have_aw, have_w;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] mem [0:7];

  assign m_axil_awready = (aw_wait >= cfg_aw_delay);
  assign m_axil_wready  = 1'b1;
  assign m_axil_arready = 1'b1;

  wire aw_hs = m_axil_awvalid & m_axil_awready;
  wire w_hs  = m_axil_wvalid & m_axil_wready;
  wire [AW-1:0] eff_addr = have_aw ? s_awaddr : m_axil_awaddr;
  wire [DW-1:0] eff_data = have_w ? s_wdata : m_axil_wdata;
  wire [SW-1:0] eff_strb = have_w ? s_wstrb : m_axil_wstrb;
  wire commit = (have_aw | aw_hs) & (have_w | w_hs) & ~m_axil_bvalid & ~cfg_b_hold;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_wait <= 0;
      have_aw <= 1'b0;
      have_w  <= 1'b0;
      s_awaddr <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      m_axil_bvalid <= 1'b0;
      m_axil_bresp  <= 2'd0;
      m_axil_rvalid <= 1'b0;
      m_axil_rdata  <= '0;
      m_axil_rresp  <= 2'd0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) aw_wait <= 0;
      else if (m_axil_awvalid) aw_wait <= aw_wait + 1;
      if (aw_hs) begin have_aw <= 1'b1; s_awaddr <= m_axil_awaddr; end
      if (w_hs) begin have_w <= 1'b1; s_wdata <= m_axil_wdata; s_wstrb <= m_axil_wstrb; end
      if (commit) begin
        mem[eff_addr[4:2]] <= merge(mem[eff_addr[4:2]], eff_data, eff_strb);
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        m_axil_bvalid <= 1'b1;
        m_axil_bresp  <= cfg_bresp;
      end else if (m_axil_bvalid && m_axil_bready) begin
        m_axil_bvalid <= 1'b0;
      end
      if (m_axil_arvalid && m_axil_arready) begin
        m_axil_rvalid <= 1'b1;
        m_axil_rdata  <= mem[m_axil_araddr[4:2]];
        m_axil_rresp  <= cfg_rresp;
      end else if (m_axil_rvalid && m_axil_rready) begin
        m_axil_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard and monitors --------------------------------
  logic [1:0]  exp_wr[$], obs_wr[$];
  logic [33:0] exp_rd[$], obs_rd[$];
  logic [31:0] model_mem [0:7];
  int unsigned n_wr_done, n_rd_done, n_aw_hi, n_w_hi, n_w_hs;

  task automatic step();
    @(negedge clk);
    if (wr_done) begin obs_wr.push_back(wr_resp); n_wr_done++; end
    if (rd_done) begin obs_rd.push_back({rd_resp, rd_data}); n_rd_done++; end
    if (m_axil_awvalid) n_aw_hi++;
    if (m_axil_wvalid) n_w_hi++;
    if (m_axil_wvalid && m_axil_wready) n_w_hs++;
  endtask

  task automatic set_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_start = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    exp_wr.push_back(cfg_bresp);
    model_mem[a[4:2]] = merge(model_mem[a[4:2]], d, s);
  endtask

  task automatic set_rd(input logic [4:0] a);
    rd_start = 1'b1; rd_addr = a;
    exp_rd.push_back({cfg_rresp, model_mem[a[4:2]]});
  endtask

  task automatic clear_starts();
    wr_start = 1'b0; rd_start = 1'b0;
  endtask

  task automatic wait_wr(input int unsigned target);
    int unsigned k = 0;
    while (n_wr_done < target && k < 64) begin step(); k++; end
  endtask

  task automatic wait_rd(input int unsigned target);
    int unsigned k = 0;
    while (n_rd_done < target && k < 64) begin step(); k++; end
  endtask

  task automatic run_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned t = n_wr_done + 1;
    set_wr(a, d, s); step(); clear_starts(); wait_wr(t);
  endtask

  task automatic run_rd(input logic [4:0] a);
    int unsigned t = n_rd_done + 1;
    set_rd(a); step(); clear_starts(); wait_rd(t);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; clear_starts();
    wr_addr = '0; wr_data = '0; wr_strb = '0; rd_addr = '0;
    cfg_aw_delay = 0; cfg_bresp = 2'd0; cfg_rresp = 2'd0; cfg_b_hold = 1'b0;
    reset_model();
    repeat (3) step();
    n_tests++;
    if ({wr_ready, rd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
         m_axil_rready, wr_done, rd_done} !== 9'b110000000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 110000000",
        {wr_ready, rd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready,
         m_axil_rready, wr_done, rd_done});
    end
    n_tests++;
    if ({wr_resp, rd_resp, rd_data, wr_err_count, rd_err_count} !== 52'd0) begin
      n_fail++; $display("FAIL reset_status: wr_resp=%0d rd_resp=%0d rd_data=%h errs=%0d/%0d want all 0",
        wr_resp, rd_resp, rd_data, wr_err_count, rd_err_count);
    end
    n_tests++;
    if ({m_axil_awaddr, m_axil_wdata, m_axil_wstrb, m_axil_araddr} !== 46'd0) begin
      n_fail++; $display("FAIL reset_regs: awaddr=%h wdata=%h wstrb=%h araddr=%h want 0",
        m_axil_awaddr, m_axil_wdata, m_axil_wstrb, m_axil_araddr);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({m_axil_awprot, m_axil_arprot, wr_ready, rd_ready} !== 8'b00000011) begin
      n_fail++; $display("FAIL idle_after_reset: prot=%b/%b ready=%b%b want 000/000 11",
        m_axil_awprot, m_axil_arprot, wr_ready, rd_ready);
    end
  endtask

  task automatic test_write_read();
    logic [1:0] o2, e2;
    logic [33:0] o34, e34;
    int unsigned base = n_wr_done;
    set_wr(5'h04, 32'h0000_2345, 4'hF);
    step(); clear_starts();
    n_tests++;
    if ({m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready} !== 4'hF ||
        m_axil_awaddr !== 5'h04 || m_axil_wdata !== 32'h0000_2345) begin
      n_fail++; $display("FAIL wr_cycle1_hs: aw=%b%b w=%b%b addr=%h data=%h want 11 11 04 00002345",
        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready, m_axil_awaddr, m_axil_wdata);
    end
    step();
    n_tests++;
    if ({m_axil_bvalid, m_axil_bready, wr_done} !== 3'b110) begin
      n_fail++; $display("FAIL wr_cycle2_b: bvalid/bready/done=%b want 110",
        {m_axil_bvalid, m_axil_bready, wr_done});
    end
    step();
    n_tests++;
    if ({wr_done, wr_ready, m_axil_bready} !== 3'b110) begin
      n_fail++; $display("FAIL wr_cycle3_done: done/ready/bready=%b want 110",
        {wr_done, wr_ready, m_axil_bready});
    end
    repeat (3) step();
    n_tests++;
    if (n_wr_done - base !== 1) begin
      n_fail++; $display("FAIL wr_single_done: got %0d pulses want 1", n_wr_done - base);
    end
    n_tests++;
    if (obs_wr.size() == 0 || exp_wr.size() == 0) begin
      n_fail++; $display("FAIL wr_sb_t1: no write response observed");
    end else begin
      o2 = obs_wr.pop_front(); e2 = exp_wr.pop_front();
      if (o2 !== e2) begin n_fail++; $display("FAIL wr_sb_t1: got %0d want %0d", o2, e2); end
    end
    set_rd(5'h04);
    step(); clear_starts();
    n_tests++;
    if ({m_axil_arvalid, m_axil_arready} !== 2'b11 || m_axil_araddr !== 5'h04) begin
      n_fail++; $display("FAIL rd_cycle1_ar: ar=%b%b addr=%h want 11 04",
        m_axil_arvalid, m_axil_arready, m_axil_araddr);
    end
    step();
    n_tests++;
    if ({m_axil_rvalid, m_axil_rready, m_axil_arvalid} !== 3'b110) begin
      n_fail++; $display("FAIL rd_cycle2_r: rvalid/rready/arvalid=%b want 110",
        {m_axil_rvalid, m_axil_rready, m_axil_arvalid});
    end
    step();
    n_tests++;
    if ({rd_done, rd_ready} !== 2'b11) begin
      n_fail++; $display("FAIL rd_cycle3_done: done/ready=%b want 11", {rd_done, rd_ready});
    end
    n_tests++;
    if (obs_rd.size() == 0 || exp_rd.size() == 0) begin
      n_fail++; $display("FAIL rd_sb_t1: no read response observed");
    end else begin
      o34 = obs_rd.pop_front(); e34 = exp_rd.pop_front();
      if (o34 !== e34) begin n_fail++; $display("FAIL rd_sb_t1: got %h want %h", o34, e34); end
    end
  endtask

  task automatic test_strobe();
    logic [33:0] o34, e34;
    run_wr(5'h08, 32'hAABB_CCDD, 4'hF);
    run_wr(5'h08, 32'h1122_3344, 4'b0011);
    run_rd(5'h08);
    n_tests++;
    if (obs_rd.size() == 0 || exp_rd.size() == 0) begin
      n_fail++; $display("FAIL rd_sb_strb: no read response observed");
    end else begin
      o34 = obs_rd.pop_front(); e34 = exp_rd.pop_front();
      if (o34 !== e34 || o34[31:0] !== 32'hAABB_3344) begin
        n_fail++; $display("FAIL rd_sb_strb: got %h want %h (data AABB3344)", o34, e34);
      end
    end
    // All-zero strobe is issued unchanged and leaves memory untouched.
    set_wr(5'h08, 32'hFFFF_FFFF, 4'h0);
    step(); clear_starts();
    n_tests++;
    if (m_axil_wvalid !== 1'b1 || m_axil_wstrb !== 4'h0) begin
      n_fail++; $display("FAIL wstrb_zero: wvalid=%b wstrb=%h want 1 0", m_axil_wvalid, m_axil_wstrb);
    end
    wait_wr(n_wr_done + 1);
    run_rd(5'h08);
    n_tests++;
    if (obs_rd.size() == 0 || exp_rd.size() == 0) begin
      n_fail++; $display("FAIL rd_sb_strb0: no read response observed");
    end else begin
      o34 = obs_rd.pop_front(); e34 = exp_rd.pop_front();
      if (o34 !== e34) begin n_fail++; $display("FAIL rd_sb_strb0: got %h want %h", o34, e34); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  task automatic test_aw_delay();
    int unsigned b_aw, b_w, b_whs, b_done;
    cfg_aw_delay = 3;
    b_aw = n_aw_hi; b_w = n_w_hi; b_whs = n_w_hs; b_done = n_wr_done;
    run_wr(5'h00, 32'h0BAD_F00D, 4'hF);
    repeat (3) step();
    n_tests++;
    if (n_aw_hi - b_aw !== 4 || n_w_hi - b_w !== 1) begin
      n_fail++; $display("FAIL aw_delay_valids: awvalid cycles=%0d wvalid cycles=%0d want 4 1",
        n_aw_hi - b_aw, n_w_hi - b_w);
    end
    n_tests++;
    if (n_w_hs - b_whs !== 1 || n_wr_done - b_done !== 1) begin
      n_fail++; $display("FAIL aw_delay_counts: w_hs=%0d done=%0d want 1 1",
        n_w_hs - b_whs, n_wr_done - b_done);
    end
    exp_wr.delete(); obs_wr.delete();
    cfg_aw_delay = 0;
  endtask

  task automatic test_err_saturate();
    logic [1:0] o2;
    logic [7:0] exp_err = wr_err_count;
    cfg_bresp = 2'd2;
    for (int i = 0; i < 300; i++) begin
      run_wr(5'h1C, 32'(i), 4'hF);
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      n_tests++;
      if (obs_wr.size() == 0 || exp_wr.size() == 0) begin
        n_fail++; $display("FAIL err_resp[%0d]: no write response observed", i);
      end else begin
        o2 = obs_wr.pop_front(); void'(exp_wr.pop_front());
        if (o2 !== 2'd2) begin n_fail++; $display("FAIL err_resp[%0d]: got %0d want 2", i, o2); end
      end
      n_tests++;
      if (wr_err_count !== exp_err) begin
        n_fail++; $display("FAIL err_count[%0d]: got %0d want %0d", i, wr_err_count, exp_err);
      end
    end
    n_tests++;
    if (wr_err_count !== 8'hFF || rd_err_count !== 8'd0) begin
      n_fail++; $display("FAIL err_saturated: wr=%0d rd=%0d want 255 0", wr_err_count, rd_err_count);
    end
    cfg_bresp = 2'd0;
  endtask

  task automatic test_busy_and_reset();
    logic [1:0] o2, e2;
    logic [33:0] o34, e34;
    int unsigned b_done, b_aw;
    cfg_b_hold = 1'b1;
    b_done = n_wr_done;
    set_wr(5'h14, 32'h5555_AAAA, 4'hF);
    step(); clear_starts();
    step(); step();
    n_tests++;
    if ({m_axil_bready, wr_ready} !== 2'b10) begin
      n_fail++; $display("FAIL busy_in_resp: bready/wr_ready=%b want 10", {m_axil_bready, wr_ready});
    end
    b_aw = n_aw_hi;
    wr_start = 1'b1; wr_addr = 5'h18; wr_data = 32'hBAD0_BAD0; wr_strb = 4'hF;
    step();
    wr_start = 1'b0;
    cfg_b_hold = 1'b0;
    wait_wr(b_done + 1);
    repeat (4) step();
    n_tests++;
    if (n_wr_done - b_done !== 1 || n_aw_hi !== b_aw) begin
      n_fail++; $display("FAIL busy_ignored: done=%0d extra_aw_cycles=%0d want 1 0",
        n_wr_done - b_done, n_aw_hi - b_aw);
    end
    n_tests++;
    if (obs_wr.size() == 0 || exp_wr.size() == 0) begin
      n_fail++; $display("FAIL wr_sb_busy: no write response observed");
    end else begin
      o2 = obs_wr.pop_front(); e2 = exp_wr.pop_front();
      if (o2 !== e2) begin n_fail++; $display("FAIL wr_sb_busy: got %0d want %0d", o2, e2); end
    end
    run_rd(5'h18);
    n_tests++;
    if (obs_rd.size() == 0 || exp_rd.size() == 0) begin
      n_fail++; $display("FAIL rd_sb_busy: no read response observed");
    end else begin
      o34 = obs_rd.pop_front(); e34 = exp_rd.pop_front();
      if (o34 !== e34) begin n_fail++; $display("FAIL rd_sb_busy: got %h want %h", o34, e34); end
    end
    // Reset while AW is still waiting; a start in the reset cycle must be lost.
    cfg_aw_delay = 3;
    set_wr(5'h1C, 32'h7777_7777, 4'hF);
    step(); clear_starts();
    step();
    n_tests++;
    if (m_axil_awvalid !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset_busy: awvalid=%b wr_ready=%b want 1 0", m_axil_awvalid, wr_ready);
    end
    rst_n = 1'b0;
    wr_start = 1'b1; wr_addr = 5'h04; wr_data = 32'h1234_5678; wr_strb = 4'hF;
    step();
    n_tests++;
    if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, wr_ready} !== 4'b0001 ||
        wr_err_count !== 8'd0 || rd_err_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_mid_write: aw/w/b/ready=%b errs=%0d/%0d want 0001 0/0",
        {m_axil_awvalid, m_axil_wvalid, m_axil_bready, wr_ready}, wr_err_count, rd_err_count);
    end
    rst_n = 1'b1; wr_start = 1'b0;
    cfg_aw_delay = 0;
    reset_model();
    step();
    n_tests++;
    if (m_axil_awvalid !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_beats_start: awvalid=%b wr_ready=%b want 0 1", m_axil_awvalid, wr_ready);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] o2, e2;
    logic [33:0] o34, e34;
    int unsigned bw = n_wr_done, br = n_rd_done;
    set_wr(5'h0C, 32'hDEAD_BEEF, 4'hF);
    set_rd(5'h10);
    step(); clear_starts();
    step(); step();
    n_tests++;
    if ({wr_done, rd_done} !== 2'b11) begin
      n_fail++; $display("FAIL concurrent_cycle3: wr_done/rd_done=%b want 11", {wr_done, rd_done});
    end
    repeat (3) step();
    n_tests++;
    if (n_wr_done - bw !== 1 || n_rd_done - br !== 1) begin
      n_fail++; $display("FAIL concurrent_pulses: wr=%0d rd=%0d want 1 1", n_wr_done - bw, n_rd_done - br);
    end
    n_tests++;
    if (obs_wr.size() == 0 || exp_wr.size() == 0) begin
      n_fail++; $display("FAIL wr_sb_conc: no write response observed");
    end else begin
      o2 = obs_wr.pop_front(); e2 = exp_wr.pop_front();
      if (o2 !== e2) begin n_fail++; $display("FAIL wr_sb_conc: got %0d want %0d", o2, e2); end
    end
    n_tests++;
    if (obs_rd.size() == 0 || exp_rd.size() == 0) begin
      n_fail++; $display("FAIL rd_sb_conc: no read response observed");
    end else begin
      o34 = obs_rd.pop_front(); e34 = exp_rd.pop_front();
      if (o34 !== e34) begin n_fail++; $display("FAIL rd_sb_conc: got %h want %h", o34, e34); end
    end
    // Read back with an error response to exercise the read error counter.
    cfg_rresp = 2'd2;
    run_rd(5'h0C);
    n_tests++;
    if (obs_rd.size() == 0 || exp_rd.size() == 0) begin
      n_fail++; $display("FAIL rd_sb_err: no read response observed");
    end else begin
      o34 = obs_rd.pop_front(); e34 = exp_rd.pop_front();
      if (o34 !== e34) begin n_fail++; $display("FAIL rd_sb_err: got %h want %h", o34, e34); end
    end
    n_tests++;
    if (rd_err_count !== 8'd1 || wr_err_count !== 8'd0) begin
      n_fail++; $display("FAIL rd_err_count: rd=%0d wr=%0d want 1 0", rd_err_count, wr_err_count);
    end
    cfg_rresp = 2'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    n_wr_done = 0; n_rd_done = 0; n_aw_hi = 0; n_w_hi = 0; n_w_hs = 0;
    test_reset();
    test_write_read();
    test_strobe();
    test_aw_delay();
    test_err_saturate();
    test_busy_and_reset();
    test_concurrent();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
